// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 strict priority instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [4:0]       psr,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   grant0, grant1, hs, gid;

  // Only SUB, CMP and ADD produce status worth keeping in psr.
  function automatic logic updates_psr(input logic [OPW-1:0] op);
    return (op == OPW'(4'b0001)) || (op == OPW'(4'b0010)) || (op == OPW'(4'b1000));
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  logic last_grant;

  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (hs)
      last_grant <= gid;
  end
`endif

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign hs         = req0_ready | req1_ready;
  assign gid        = req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      psr        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (hs) begin
          alu_a    <= gid ? req1_a  : req0_a;
          alu_b    <= gid ? req1_b  : req0_b;
          alu_ctrl <= gid ? req1_op : req0_op;
          rsp_id   <= gid;
        end
        // ALU is combinational: its output for the latched operands is valid here.
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_valid  <= 1'b1;
          alu_ctrl   <= '0;
          if (updates_psr(alu_ctrl))
            psr <= alu_flags;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; the ALU is stubbed with hand-computed results per op.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [4:0]  rsp_flags, psr, alu_flags;
  logic [3:0]  alu_ctrl;

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .psr(psr), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present an op on one port with the ALU stub answer, wait for accept, drop valid after the handshake edge.
  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input logic [15:0] res, input logic [4:0] flg);
    int cnt;
    @(negedge clk);
    alu_result = res;
    alu_flags  = flg;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    cnt = 0;
    while (!(id ? req1_ready : req0_ready) && cnt < 20) begin
      @(negedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt >= 20) begin
      errors++;
      $display("FAIL accept_timeout: port %0d not accepted within %0d cycles", id, cnt);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called right after issue(): checks the EXEC cycle then the first RESP cycle.
  task automatic expect_rsp(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                            input logic [15:0] res, input logic [4:0] flg, input logic [4:0] psr_exp);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_ctrl !== op || alu_a !== a || alu_b !== b) begin
      errors++;
      $display("FAIL exec_drive: busy=%b ctrl=%h a=%h b=%h, expected busy=1 ctrl=%h a=%h b=%h",
               busy, alu_ctrl, alu_a, alu_b, op, a, b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== id) begin
      errors++;
      $display("FAIL rsp_hdr: valid=%b id=%b, expected valid=1 id=%b", rsp_valid, rsp_id, id);
    end
    checks++;
    if (rsp_result !== res || rsp_flags !== flg) begin
      errors++;
      $display("FAIL rsp_data: result=%h flags=%b, expected result=%h flags=%b", rsp_result, rsp_flags, res, flg);
    end
    checks++;
    if (psr !== psr_exp || alu_ctrl !== 4'b0000) begin
      errors++;
      $display("FAIL psr: psr=%b ctrl=%h, expected psr=%b ctrl=0", psr, alu_ctrl, psr_exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || psr !== 5'b0 || alu_ctrl !== 4'b0 ||
        alu_a !== 16'h0 || alu_b !== 16'h0 || rsp_result !== 16'h0 || rsp_flags !== 5'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rv=%b psr=%b ctrl=%h a=%h b=%h res=%h flg=%b id=%b, expected all 0",
               busy, rsp_valid, psr, alu_ctrl, alu_a, alu_b, rsp_result, rsp_flags, rsp_id);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: r0=%b r1=%b, expected 0 0", req0_ready, req1_ready);
    end
  endtask

  task automatic test_ops();
    issue(0, 16'hFFFF, 16'h0001, 4'b1000, 16'h0000, 5'b10100);
    expect_rsp(0, 16'hFFFF, 16'h0001, 4'b1000, 16'h0000, 5'b10100, 5'b10100);
    issue(1, 16'h0005, 16'h0003, 4'b0001, 16'hFFFE, 5'b10100);
    expect_rsp(1, 16'h0005, 16'h0003, 4'b0001, 16'hFFFE, 5'b10100, 5'b10100);
    issue(1, 16'h00F0, 16'h0FF0, 4'b0011, 16'h00F0, 5'b00000);
    expect_rsp(1, 16'h00F0, 16'h0FF0, 4'b0011, 16'h00F0, 5'b00000, 5'b10100);
    issue(0, 16'h0007, 16'h0007, 4'b0010, 16'h0000, 5'b00010);
    expect_rsp(0, 16'h0007, 16'h0007, 4'b0010, 16'h0000, 5'b00010, 5'b00010);
    // Undefined opcode passes through to the ALU and leaves psr alone.
    issue(1, 16'h1234, 16'h5678, 4'b0110, 16'h0000, 5'b00000);
    expect_rsp(1, 16'h1234, 16'h5678, 4'b0110, 16'h0000, 5'b00000, 5'b00010);
    issue(0, 16'h0009, 16'h0002, 4'b0010, 16'h0000, 5'b01001);
    expect_rsp(0, 16'h0009, 16'h0002, 4'b0010, 16'h0000, 5'b01001, 5'b01001);
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    issue(1, 16'h0002, 16'h0003, 4'b1000, 16'h0005, 5'b00000);
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_op    = 4'b1000;
    @(negedge clk);
    held = rsp_result;
    checks++;
    if (held !== 16'h0005) begin
      errors++;
      $display("FAIL bp_result: got %h expected 0005", held);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || rsp_id !== 1'b1 || req0_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b res=%h id=%b r0_ready=%b, expected 1 %h 1 0",
                 i, rsp_valid, rsp_result, rsp_id, req0_ready, held);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: valid=%b busy=%b r0_ready=%b, expected 0 0 1", rsp_valid, busy, req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gid[$];
    int gcyc[$];
    int exp_id[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    do_reset();
    alu_result = 16'h0000;
    alu_flags  = 5'b00000;
    req0_valid = 1'b1; req0_op = 4'b0011;
    req1_valid = 1'b1; req1_op = 4'b0100;
    for (int c = 0; c < 30 && gid.size() < 4; c++) begin
      #1;
      if (req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
      if (req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (gid.size() !== 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants expected 4", gid.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gid[i] !== exp_id[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gid[i], exp_id[i]);
        end
      end
      checks++;
      if (gcyc[1] - gcyc[0] !== 3 || gcyc[3] - gcyc[2] !== 3) begin
        errors++;
        $display("FAIL rr_spacing: got %0d/%0d cycles expected 3", gcyc[1] - gcyc[0], gcyc[3] - gcyc[2]);
      end
    end
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
  endtask

  task automatic test_reset_exec();
    issue(0, 16'h1111, 16'h2222, 4'b1000, 16'h3333, 5'b11111);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_ctrl !== 4'b0 || psr !== 5'b0) begin
      errors++;
      $display("FAIL reset_exec: busy=%b rv=%b ctrl=%h psr=%b, expected all 0", busy, rsp_valid, alu_ctrl, psr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_drop[%0d]: rv=%b busy=%b, expected 0 0", i, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    alu_result = '0; alu_flags = '0;
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    // Re-establish a nonzero psr so the reset check is meaningful.
    issue(0, 16'h0009, 16'h0002, 4'b0010, 16'h0000, 5'b01001);
    expect_rsp(0, 16'h0009, 16'h0002, 4'b0010, 16'h0000, 5'b01001, 5'b01001);
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
